i2s_tx_channel: RTL and testbench

I2S_TX_CHANNEL -- requirements
Module: i2s_tx_channel

---
 rtl/i2s_tx_channel.sv | 165 ++++++++++++++++
 tb/tb_i2s_tx_channel.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_channel.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_channel
//  Description : I2S transmit channel. Two prefetch buffers feed one or two
//                serial shift registers. Words restart on word-select edges.
//                Optional macro I2S_TX_UNDERRUN_REPEAT_EN makes an underrun
//                resend the channel's last word instead of zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_channel (
  input  logic        sck_i,
  input  logic        rst_i,
  input  logic        i2s_ws_i,
  output logic        i2s_ch0_o,
  output logic        i2s_ch1_o,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_data_valid_i,
  output logic        fifo_data_ready_o,
  output logic        fifo_err_o,
  input  logic        cfg_en_i,
  input  logic        cfg_2ch_i,
  input  logic [4:0]  cfg_wlen_i,
  input  logic        cfg_lsb_first_i
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_wait_ws = 2'd1;
  localparam logic [1:0] c_run     = 2'd2;

  logic [1:0]  r_ws_sync;
  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_buf0;
  logic [31:0] r_buf1;
  logic        r_buf0_v;
  logic        r_buf1_v;
  logic [31:0] r_sh0;
  logic [31:0] r_sh1;
  logic        r_err;

  logic        w_ws_edge;
  logic        w_accept;
  logic        w_reload;
  logic        w_under;
  logic        w_stop;
  logic [31:0] w_fill0;
  logic [31:0] w_fill1;
  logic [31:0] w_load0;
  logic [31:0] w_load1;

  assign w_ws_edge = r_ws_sync[1] ^ r_ws_sync[0];
  assign fifo_data_ready_o = (r_state != c_idle) & (~r_buf0_v | (cfg_2ch_i & ~r_buf1_v));
  assign w_accept = fifo_data_valid_i & fifo_data_ready_o;

  // Leaving RUN on a word-select edge with the channel disabled wins over a reload.
  assign w_stop = (r_state == c_run) & w_ws_edge & ~cfg_en_i;

  // A reload happens when RUN is entered and at the last bit of every word.
  assign w_reload = ((r_state == c_wait_ws) & cfg_en_i & w_ws_edge) |
                    ((r_state == c_run) & ~w_stop & (r_cnt == cfg_wlen_i));

  assign w_under = ~r_buf0_v | (cfg_2ch_i & ~r_buf1_v);

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [31:0] r_last0;
  logic [31:0] r_last1;

  // Remember the last word actually loaded from each buffer for underrun repeat.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_last0 <= 32'h0;
      r_last1 <= 32'h0;
    end else if (w_reload) begin
      if (r_buf0_v) r_last0 <= r_buf0;
      if (cfg_2ch_i && r_buf1_v) r_last1 <= r_buf1;
    end
  end

  assign w_fill0 = r_last0;
  assign w_fill1 = r_last1;
`else
  assign w_fill0 = 32'h0;
  assign w_fill1 = 32'h0;
`endif

  assign w_load0 = r_buf0_v ? r_buf0 : w_fill0;
  assign w_load1 = !cfg_2ch_i ? 32'h0 : (r_buf1_v ? r_buf1 : w_fill1);

  // Word-select synchroniser and channel state machine.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_ws_sync <= 2'b00;
      r_state   <= c_idle;
    end else begin
      r_ws_sync <= {r_ws_sync[0], i2s_ws_i};
      case (r_state)
        c_idle:    if (cfg_en_i) r_state <= c_wait_ws;
        c_wait_ws: begin
          if (!cfg_en_i)      r_state <= c_idle;
          else if (w_ws_edge) r_state <= c_run;
        end
        c_run:     if (w_stop) r_state <= c_idle;
        default:   r_state <= c_idle;
      endcase
    end
  end

  // Prefetch buffers; a reload frees both, so a same-cycle word lands in buf0.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_buf0   <= 32'h0;
      r_buf1   <= 32'h0;
      r_buf0_v <= 1'b0;
      r_buf1_v <= 1'b0;
    end else if (r_state == c_idle) begin
      r_buf0_v <= 1'b0;
      r_buf1_v <= 1'b0;
    end else if (w_reload) begin
      r_buf1_v <= 1'b0;
      r_buf0_v <= w_accept;
      if (w_accept) r_buf0 <= fifo_data_i;
    end else if (w_accept) begin
      if (!r_buf0_v) begin
        r_buf0   <= fifo_data_i;
        r_buf0_v <= 1'b1;
      end else begin
        r_buf1   <= fifo_data_i;
        r_buf1_v <= 1'b1;
      end
    end
  end

  // Shift registers, bit counter and underrun pulse.
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      r_sh0 <= 32'h0;
      r_sh1 <= 32'h0;
      r_cnt <= 5'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_reload & w_under;
      if (w_reload) begin
        r_sh0 <= w_load0;
        r_sh1 <= w_load1;
        r_cnt <= 5'd0;
      end else if ((r_state == c_run) && (r_cnt != cfg_wlen_i)) begin
        r_cnt <= r_cnt + 5'd1;
        if (cfg_lsb_first_i) begin
          r_sh0 <= r_sh0 >> 1;
          r_sh1 <= r_sh1 >> 1;
        end else begin
          r_sh0 <= r_sh0 << 1;
          r_sh1 <= r_sh1 << 1;
        end
      end
    end
  end

  assign fifo_err_o = r_err;
  assign i2s_ch0_o  = (r_state == c_run) & (cfg_lsb_first_i ? r_sh0[0] : r_sh0[cfg_wlen_i]);
  assign i2s_ch1_o  = (r_state == c_run) & cfg_2ch_i &
                      (cfg_lsb_first_i ? r_sh1[0] : r_sh1[cfg_wlen_i]);

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_channel
//  Description : Self-checking bench for i2s_tx_channel. Expected serial
//                streams are computed from the queued words and frame timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_channel;

  logic        sck_i = 1'b0;
  logic        rst_i;
  logic        i2s_ws_i;
  logic        i2s_ch0_o;
  logic        i2s_ch1_o;
  logic [31:0] fifo_data_i;
  logic        fifo_data_valid_i;
  logic        fifo_data_ready_o;
  logic        fifo_err_o;
  logic        cfg_en_i;
  logic        cfg_2ch_i;
  logic [4:0]  cfg_wlen_i;
  logic        cfg_lsb_first_i;

  int n_tests = 0;
  int n_fail  = 0;
  int sent    = 0;
  logic [31:0] q[$];
  logic [31:0] r0;
  logic [31:0] r1;

  i2s_tx_channel dut (
    .sck_i             (sck_i),
    .rst_i             (rst_i),
    .i2s_ws_i          (i2s_ws_i),
    .i2s_ch0_o         (i2s_ch0_o),
    .i2s_ch1_o         (i2s_ch1_o),
    .fifo_data_i       (fifo_data_i),
    .fifo_data_valid_i (fifo_data_valid_i),
    .fifo_data_ready_o (fifo_data_ready_o),
    .fifo_err_o        (fifo_err_o),
    .cfg_en_i          (cfg_en_i),
    .cfg_2ch_i         (cfg_2ch_i),
    .cfg_wlen_i        (cfg_wlen_i),
    .cfg_lsb_first_i   (cfg_lsb_first_i)
  );

  always #5 sck_i = ~sck_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; i2s_ws_i = 1'b0; cfg_en_i = 1'b0; fifo_data_valid_i = 1'b0;
    repeat (2) @(posedge sck_i);
    #1 rst_i = 1'b0;
  endtask

  // One clock: offer the next queued word, advance, and count it if taken.
  task automatic step();
    logic acc;
    if (sent < q.size()) begin
      fifo_data_valid_i = 1'b1;
      fifo_data_i       = q[sent];
    end else begin
      fifo_data_valid_i = 1'b0;
      fifo_data_i       = $urandom;
    end
    acc = fifo_data_valid_i & fifo_data_ready_o;
    @(posedge sck_i);
    #1;
    if (acc) sent++;
  endtask

  // Prefill, then run n frames of (wl+1) cycles; drop enable in the last frame.
  // abort_bit >= 0 pulses reset while bit abort_bit of frame 0 is on the line.
  task automatic run_stream(input bit two, input int wl, input bit lsb, input int n,
                            input int abort_bit, output logic [31:0] obs0,
                            output logic [31:0] obs1);
    int w   = wl + 1;
    int nch = two ? 2 : 1;
    int f, k, idx, t;
    bit und;
    logic [31:0] e0, e1, last0, last1, rep0, rep1;
    logic exp0, exp1;
    last0 = 32'h0; last1 = 32'h0; e0 = 32'h0; e1 = 32'h0; und = 1'b0;
    obs0 = 32'h0; obs1 = 32'h0;
    sent = 0;
    cfg_2ch_i = two; cfg_wlen_i = 5'(wl); cfg_lsb_first_i = lsb; cfg_en_i = 1'b1;
    repeat (5) step();
    check("prefill_ready", {31'h0, fifo_data_ready_o}, {31'h0, (q.size() < nch)});
    for (int c = 0; c <= n * w + 1; c++) begin
      if ((c % w == 0) && (c <= n * w)) i2s_ws_i = ~i2s_ws_i;
      if (c == (n - 1) * w + 2) cfg_en_i = 1'b0;
      step();
      t = c + 1;
      if (t < 2) begin
        check("pre_ch0", {31'h0, i2s_ch0_o}, 32'h0);
        check("pre_err", {31'h0, fifo_err_o}, 32'h0);
      end else if (t <= n * w + 1) begin
        f = (t - 2) / w;
        k = (t - 2) % w;
        if (k == 0) begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
          rep0 = last0; rep1 = last1;
`else
          rep0 = 32'h0; rep1 = 32'h0;
`endif
          idx = f * nch;
          und = 1'b0;
          if (idx < q.size()) begin e0 = q[idx]; last0 = e0; end
          else begin e0 = rep0; und = 1'b1; end
          e1 = 32'h0;
          if (two) begin
            if (idx + 1 < q.size()) begin e1 = q[idx + 1]; last1 = e1; end
            else begin e1 = rep1; und = 1'b1; end
          end
        end
        exp0 = lsb ? e0[k] : e0[wl - k];
        exp1 = lsb ? e1[k] : e1[wl - k];
        check("ch0_bit", {31'h0, i2s_ch0_o}, {31'h0, exp0});
        check("ch1_bit", {31'h0, i2s_ch1_o}, {31'h0, exp1});
        check("err", {31'h0, fifo_err_o}, {31'h0, (k == 0) && und});
        if (f == 0) begin
          obs0 = {obs0[30:0], i2s_ch0_o};
          obs1 = {obs1[30:0], i2s_ch1_o};
        end
        if ((abort_bit >= 0) && (f == 0) && (k == abort_bit)) begin
          rst_i = 1'b1; i2s_ws_i = 1'b0; cfg_en_i = 1'b0; fifo_data_valid_i = 1'b0;
          @(posedge sck_i);
          #1;
          check("abort_ch0", {31'h0, i2s_ch0_o}, 32'h0);
          check("abort_ch1", {31'h0, i2s_ch1_o}, 32'h0);
          check("abort_ready", {31'h0, fifo_data_ready_o}, 32'h0);
          check("abort_err", {31'h0, fifo_err_o}, 32'h0);
          rst_i = 1'b0;
          return;
        end
      end else begin
        check("idle_ch0", {31'h0, i2s_ch0_o}, 32'h0);
        check("idle_ch1", {31'h0, i2s_ch1_o}, 32'h0);
        check("idle_ready", {31'h0, fifo_data_ready_o}, 32'h0);
        check("idle_err", {31'h0, fifo_err_o}, 32'h0);
      end
    end
  endtask

  initial begin
    cfg_2ch_i = 1'b0; cfg_wlen_i = 5'd0; cfg_lsb_first_i = 1'b0; fifo_data_i = 32'h0;
    do_reset();
    check("rst_ch0", {31'h0, i2s_ch0_o}, 32'h0);
    check("rst_ch1", {31'h0, i2s_ch1_o}, 32'h0);
    check("rst_ready", {31'h0, fifo_data_ready_o}, 32'h0);
    check("rst_err", {31'h0, fifo_err_o}, 32'h0);

    // Mono, 16-bit, MSB first.
    q = '{32'h0000A5C3};
    run_stream(1'b0, 15, 1'b0, 1, -1, r0, r1);
    check("mono_msb_word", r0, 32'h0000A5C3);
    check("mono_msb_ch1", r1, 32'h0);

    // Same word, LSB first.
    do_reset();
    q = '{32'h0000A5C3};
    run_stream(1'b0, 15, 1'b1, 1, -1, r0, r1);
    check("mono_lsb_word", r0, 32'h0000C3A5);

    // Stereo, 8-bit: both channels simultaneous.
    do_reset();
    q = '{32'h11, 32'h22};
    run_stream(1'b1, 7, 1'b0, 1, -1, r0, r1);
    check("stereo_ch0", r0, 32'h11);
    check("stereo_ch1", r1, 32'h22);

    // Stereo with a missing right-channel word in the second frame.
    do_reset();
    q = '{32'h5A, 32'h3C, 32'h77};
    run_stream(1'b1, 7, 1'b0, 2, -1, r0, r1);

    // Reset at bit 5 of a 24-bit word, then a fresh word without further reset.
    do_reset();
    q = '{$urandom, $urandom, $urandom};
    run_stream(1'b0, 23, 1'b0, 2, 5, r0, r1);
    q = '{$urandom};
    run_stream(1'b0, 23, 1'b0, 1, -1, r0, r1);
    check("fresh_word", r0, q[0] & 32'h00FF_FFFF);

    // Randomised configurations and words, sometimes one word short.
    for (int s = 0; s < 6; s++) begin
      int nch, wl, nw;
      bit two;
      two = 1'($urandom_range(0, 1));
      nch = two ? 2 : 1;
      wl  = int'($urandom_range(2, 31));
      nw  = 3 * nch - int'($urandom_range(0, 1));
      do_reset();
      q.delete();
      for (int i = 0; i < nw; i++) q.push_back($urandom);
      run_stream(two, wl, 1'($urandom_range(0, 1)), 3, -1, r0, r1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
